simple_ram_writer: RTL and testbench

- Write-side companion to the delayed-read RAM wrapper. It owns the RAM write port: wr_data/wr_addr/wr_enable.
- Accepts a valid/ready stream of (addr, data) update commands and runs a full-table clear sweep on reset or on request.
- Sits between the table-update/control logic and the quadtree level RAMs, so the lookup pipeline only ever reads initialised contents.

---
 rtl/simple_ram_writer_pkg.sv | 4 +
 rtl/simple_ram_writer.sv | 57 +++++
 tb/tb_simple_ram_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/simple_ram_writer_pkg.sv
// simple_ram_writer_pkg: shared state type for the RAM write-port owner
package simple_ram_writer_pkg;
    typedef enum logic {IDLE_S, CLEAR_S} state_t;
endpackage

// File: rtl/simple_ram_writer.sv
// simple_ram_writer: RAM write port driver for command stream writes and full-table clear sweeps
module simple_ram_writer
    import simple_ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  clear_req_i,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  wr_enable_o,
    output logic                  busy_o,
    output logic                  clear_done_o
);
    state_t state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    assign in_ready_o = rst_i && (state == IDLE_S) && !clear_req_i;
    assign busy_o = (state == CLEAR_S);
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= CLEAR_ON_RESET ? CLEAR_S : IDLE_S;
            clr_addr <= '0;
            wr_enable_o <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            clear_done_o <= 1'b0;
        end else if (state == CLEAR_S) begin
            wr_enable_o <= 1'b1;
            wr_addr_o <= clr_addr;
            wr_data_o <= CLEAR_VALUE;
            clr_addr <= clr_addr + 1'b1;
            clear_done_o <= &clr_addr;
            if (&clr_addr) state <= IDLE_S;
        end else begin
            clear_done_o <= 1'b0;
            if (clear_req_i) begin
                state <= CLEAR_S;
                clr_addr <= '0;
                wr_enable_o <= 1'b0;
            end else if (in_valid_i && in_ready_o) begin
                wr_enable_o <= 1'b1;
                wr_addr_o <= in_addr_i;
                wr_data_o <= in_data_i;
            end else begin
                wr_enable_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simple_ram_writer.sv
// tb_simple_ram_writer: directed scenario bench for simple_ram_writer with a RAM model
module tb_simple_ram_writer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic [2:0] in_addr_i = '0;
    logic [7:0] in_data_i = '0;
    logic in_valid_i = 1'b0;
    logic in_ready_o;
    logic clear_req_i = 1'b0;
    logic [7:0] wr_data_o;
    logic [2:0] wr_addr_o;
    logic wr_enable_o;
    logic busy_o;
    logic clear_done_o;
    logic [7:0] mem [8];
    int vectors = 0;
    int miscompares = 0;

    simple_ram_writer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .CLEAR_VALUE(8'hA5),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .in_addr_i(in_addr_i),
        .in_data_i(in_data_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .clear_req_i(clear_req_i),
        .wr_data_o(wr_data_o),
        .wr_addr_o(wr_addr_o),
        .wr_enable_o(wr_enable_o),
        .busy_o(busy_o),
        .clear_done_o(clear_done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (wr_enable_o) mem[wr_addr_o] <= wr_data_o;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (wr_enable_o !== 1'b0 || clear_done_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: en=%b done=%b busy=%b rdy=%b, want en=0 done=0 busy=1 rdy=0", wr_enable_o, clear_done_o, busy_o, in_ready_o);
            end
        end
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (wr_enable_o !== 1'b1 || wr_addr_o !== i[2:0] || wr_data_o !== 8'hA5 || clear_done_o !== (i == 7) || busy_o !== (i != 7) || in_ready_o !== (i == 7)) begin
                miscompares++;
                $display("FAIL reset_sweep[%0d]: en=%b addr=%0d data=%h done=%b busy=%b rdy=%b", i, wr_enable_o, wr_addr_o, wr_data_o, clear_done_o, busy_o, in_ready_o);
            end
        end
        step();
        vectors++;
        if (wr_enable_o !== 1'b0 || in_ready_o !== 1'b1 || clear_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after: en=%b rdy=%b done=%b, want en=0 rdy=1 done=0", wr_enable_o, in_ready_o, clear_done_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] a [3];
        logic [7:0] d [3];
        a = '{3'd2, 3'd5, 3'd2};
        d = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_addr_i = a[i];
            in_data_i = d[i];
            #1;
            vectors++;
            if (in_ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: rdy=%b want 1", i, in_ready_o);
            end
            step();
            vectors++;
            if (wr_enable_o !== 1'b1 || wr_addr_o !== a[i] || wr_data_o !== d[i]) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h", i, wr_enable_o, wr_addr_o, wr_data_o, a[i], d[i]);
            end
        end
        in_valid_i = 1'b0;
        step();
        vectors++;
        if (wr_enable_o !== 1'b0 || wr_addr_o !== 3'd2 || wr_data_o !== 8'h33) begin
            miscompares++;
            $display("FAIL b2b_idle: en=%b addr=%0d data=%h, want en=0 addr=2 data=33", wr_enable_o, wr_addr_o, wr_data_o);
        end
        step();
        vectors++;
        if (mem[2] !== 8'h33 || mem[5] !== 8'h22 || mem[0] !== 8'hA5 || mem[7] !== 8'hA5) begin
            miscompares++;
            $display("FAIL b2b_ram: m0=%h m2=%h m5=%h m7=%h, want A5 33 22 A5", mem[0], mem[2], mem[5], mem[7]);
        end
    endtask

    task automatic test_clear_priority();
        clear_req_i = 1'b1;
        in_valid_i = 1'b1;
        in_addr_i = 3'd6;
        in_data_i = 8'h77;
        #1;
        vectors++;
        if (in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_ready: rdy=%b want 0", in_ready_o);
        end
        step();
        clear_req_i = 1'b0;
        vectors++;
        if (wr_enable_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_start: en=%b busy=%b, want en=0 busy=1", wr_enable_o, busy_o);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (wr_enable_o !== 1'b1 || wr_addr_o !== i[2:0] || wr_data_o !== 8'hA5 || clear_done_o !== (i == 7) || busy_o !== (i != 7) || in_ready_o !== (i == 7)) begin
                miscompares++;
                $display("FAIL prio_sweep[%0d]: en=%b addr=%0d data=%h done=%b busy=%b rdy=%b", i, wr_enable_o, wr_addr_o, wr_data_o, clear_done_o, busy_o, in_ready_o);
            end
        end
        step();
        in_valid_i = 1'b0;
        vectors++;
        if (wr_enable_o !== 1'b1 || wr_addr_o !== 3'd6 || wr_data_o !== 8'h77 || clear_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL held_cmd: en=%b addr=%0d data=%h done=%b, want en=1 addr=6 data=77 done=0", wr_enable_o, wr_addr_o, wr_data_o, clear_done_o);
        end
        step();
        vectors++;
        if (mem[6] !== 8'h77 || mem[2] !== 8'hA5 || mem[5] !== 8'hA5) begin
            miscompares++;
            $display("FAIL prio_ram: m6=%h m2=%h m5=%h, want 77 A5 A5", mem[6], mem[2], mem[5]);
        end
    endtask

    task automatic test_clear_ignored();
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            clear_req_i = (i == 3);
            vectors++;
            if (wr_enable_o !== 1'b1 || wr_addr_o !== i[2:0] || wr_data_o !== 8'hA5 || clear_done_o !== (i == 7) || busy_o !== (i != 7)) begin
                miscompares++;
                $display("FAIL ign_sweep[%0d]: en=%b addr=%0d data=%h done=%b busy=%b", i, wr_enable_o, wr_addr_o, wr_data_o, clear_done_o, busy_o);
            end
        end
        step();
        vectors++;
        if (wr_enable_o !== 1'b0 || clear_done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_after: en=%b done=%b busy=%b, want 0 0 0", wr_enable_o, clear_done_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_sweep();
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (wr_enable_o !== 1'b1 || wr_addr_o !== 3'd4) begin
            miscompares++;
            $display("FAIL mid_pre: en=%b addr=%0d, want en=1 addr=4", wr_enable_o, wr_addr_o);
        end
        rst_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (wr_enable_o !== 1'b0 || clear_done_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_rst[%0d]: en=%b done=%b busy=%b rdy=%b", c, wr_enable_o, clear_done_o, busy_o, in_ready_o);
            end
        end
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (wr_enable_o !== 1'b1 || wr_addr_o !== i[2:0] || wr_data_o !== 8'hA5 || clear_done_o !== (i == 7) || busy_o !== (i != 7)) begin
                miscompares++;
                $display("FAIL mid_sweep[%0d]: en=%b addr=%0d data=%h done=%b busy=%b", i, wr_enable_o, wr_addr_o, wr_data_o, clear_done_o, busy_o);
            end
        end
        step();
        vectors++;
        if (wr_enable_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after: en=%b rdy=%b, want en=0 rdy=1", wr_enable_o, in_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_clear_priority();
        test_clear_ignored();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
